// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, constants and chunk sizing for the split load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam int unsigned LSU_MAX_BYTES = 8;

  // Largest naturally aligned transfer that starts at addr and does not overrun the request.
  function automatic logic [3:0] chunk_size(input logic [2:0] addr, input logic [3:0] remaining);
    if (addr == 3'd0 && remaining >= 4'd8) begin
      return 4'd8;
    end else if (addr[1:0] == 2'd0 && remaining >= 4'd4) begin
      return 4'd4;
    end else if (addr[0] == 1'b0 && remaining >= 4'd2) begin
      return 4'd2;
    end else begin
      return 4'd1;
    end
  endfunction

endpackage

// File: rtl/lsu_chunker.sv
// rtl/lsu_chunker.sv - combinational chunk size, byte lane shift and byte mask for one beat
module lsu_chunker
  import lsu_pkg::*;
(
  input  logic [2:0]  addr_lo_i,
  input  logic [2:0]  base_lo_i,
  input  logic [3:0]  remaining_i,
  output logic [3:0]  chunk_o,
  output logic [5:0]  shift_o,
  output logic [63:0] mask_o
);

  logic [2:0] offset;

  // Offset into the request never exceeds 7, so the low address bits alone recover it.
  always_comb begin
    offset  = addr_lo_i - base_lo_i;
    chunk_o = chunk_size(addr_lo_i, remaining_i);
    shift_o = {offset, 3'b000};
    unique case (chunk_o)
      4'd1:    mask_o = 64'h0000_0000_0000_00FF;
      4'd2:    mask_o = 64'h0000_0000_0000_FFFF;
      4'd4:    mask_o = 64'h0000_0000_FFFF_FFFF;
      default: mask_o = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

endmodule

// File: rtl/mem_split_lsu.sv
// rtl/mem_split_lsu.sv - splits unaligned loads/stores into aligned datamem beats and reassembles loads
module mem_split_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  output logic [63:0] mem_address,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [63:0] mem_write_data,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_read_data
);

  localparam logic [64:0] MEM_LIMIT = 65'(MEM_SIZE);

  lsu_state_t  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  base_q, base_d;
  logic [3:0]  rem_q, rem_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] buf_q, buf_d;

  logic [3:0]  chunk;
  logic [5:0]  shift;
  logic [63:0] mask;
  logic [64:0] end_addr;
  logic        size_ok;

  lsu_chunker u_chunker (
    .addr_lo_i   (addr_q[2:0]),
    .base_lo_i   (base_q),
    .remaining_i (rem_q),
    .chunk_o     (chunk),
    .shift_o     (shift),
    .mask_o      (mask)
  );

  // Request validation; the 65-bit sum keeps a near-2^64 address from wrapping past the bound.
  always_comb begin
    end_addr = {1'b0, req_addr} + 65'(req_size);
    size_ok  = (req_size == 4'd1) || (req_size == 4'd2) || (req_size == 4'd4) ||
               (req_size == 4'(LSU_MAX_BYTES));
  end

  // Next-state, beat issue and response generation.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    base_d           = base_q;
    rem_d            = rem_q;
    write_d          = write_q;
    err_d            = err_q;
    wdata_d          = wdata_q;
    buf_d            = buf_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_err         = 1'b0;
    resp_rdata       = '0;
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_data   = '0;
    mem_xfer_size    = 4'd8;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          base_d  = req_addr[2:0];
          rem_d   = req_size;
          write_d = req_write;
          wdata_d = req_wdata;
          buf_d   = '0;
          if (!size_ok || end_addr > MEM_LIMIT) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        mem_address      = addr_q;
        mem_xfer_size    = chunk;
        mem_write_enable = write_q;
        mem_read_enable  = ~write_q;
        if (write_q) begin
          mem_write_data = wdata_q >> shift;
        end else begin
          buf_d = (buf_q & ~(mask << shift)) | ((mem_read_data & mask) << shift);
        end
        addr_d = addr_q + 64'(chunk);
        rem_d  = rem_q - chunk;
        if (rem_q == chunk) begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (write_q || err_q) ? 64'd0 : buf_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      rem_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      write_q <= write_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_mem_split_lsu.sv
// tb/tb_mem_split_lsu.sv - directed and randomized self-checking bench for mem_split_lsu
module tb_mem_split_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [3:0]  req_size;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;
  logic [3:0]  mem_xfer_size;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int en_cnt = 0;

  logic [7:0] mem [1024] = '{default: 8'h00};
  logic [7:0] ref_mem [1024] = '{default: 8'h00};

  logic [63:0] b_addr [8];
  logic [3:0]  b_size [8];
  logic [63:0] b_wd   [8];
  int          nbeats, lat;
  logic        r_err;
  logic [63:0] r_data;

  always #5 clk = ~clk;

  mem_split_lsu #(.MEM_SIZE(1024)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_size         (req_size),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_err         (resp_err),
    .resp_rdata       (resp_rdata),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_write_data   (mem_write_data),
    .mem_xfer_size    (mem_xfer_size),
    .mem_read_data    (mem_read_data)
  );

  // datamem model: combinational read, write on the clock edge
  always_comb begin
    mem_read_data = '0;
    if (mem_read_enable) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(mem_xfer_size)) mem_read_data[8*k +: 8] = mem[(int'(mem_address[9:0]) + k) & 1023];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_write_enable) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(mem_xfer_size)) mem[(int'(mem_address[9:0]) + k) & 1023] <= mem_write_data[8*k +: 8];
      end
    end
  end

  // datamem alignment / protocol monitor
  always @(negedge clk) begin
    if (mem_write_enable || mem_read_enable) begin
      en_cnt++;
      if (mem_write_enable && mem_read_enable) viol++;
      if (!(mem_xfer_size == 4'd1 || mem_xfer_size == 4'd2 || mem_xfer_size == 4'd4 || mem_xfer_size == 4'd8)) viol++;
      else if ((mem_address % 64'(mem_xfer_size)) != 64'd0) viol++;
      if (mem_address + 64'(mem_xfer_size) > 64'd1024) viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [63:0] a, input logic [3:0] sz, input logic [63:0] wd);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz; req_wdata = wd;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    nbeats = 0; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if ((mem_write_enable || mem_read_enable) && nbeats < 8) begin
        b_addr[nbeats] = mem_address; b_size[nbeats] = mem_xfer_size; b_wd[nbeats] = mem_write_data;
        nbeats++;
      end
    end while (!resp_valid && lat < 20);
    r_err = resp_err; r_data = resp_rdata;
    if (wr && !r_err) begin
      for (int k = 0; k < int'(sz); k++) ref_mem[(int'(a[9:0]) + k) & 1023] = wd[8*k +: 8];
    end
  endtask

  localparam logic [63:0] PAT = 64'h0123_4567_89AB_CDEF;

  initial begin
    int cyc, acc, e0;
    logic [63:0] ra, ev;
    logic [3:0]  rs;
    logic        rw, eerr;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = 4'd1; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_en", {62'd0, mem_write_enable, mem_read_enable}, 64'd0);
    check("rst_addr", mem_address, 64'd0);
    check("rst_wdata", mem_write_data, 64'd0);
    check("rst_xsize", 64'(mem_xfer_size), 64'd8);

    // aligned store / load
    do_req(1'b1, 64'd16, 4'd8, PAT);
    check("al_st_lat", 64'(lat), 64'd2);
    check("al_st_beats", 64'(nbeats), 64'd1);
    check("al_st_addr", b_addr[0], 64'd16);
    check("al_st_size", 64'(b_size[0]), 64'd8);
    check("al_st_err", 64'(r_err), 64'd0);
    check("al_st_rdata", r_data, 64'd0);
    do_req(1'b0, 64'd16, 4'd8, 64'd0);
    check("al_ld_lat", 64'(lat), 64'd2);
    check("al_ld_data", r_data, PAT);

    // misaligned store / load
    do_req(1'b1, 64'd3, 4'd8, PAT);
    check("mis_st_lat", 64'(lat), 64'd5);
    check("mis_st_beats", 64'(nbeats), 64'd4);
    check("mis_b0", {b_addr[0][15:0], 12'd0, b_size[0], 32'(b_wd[0][7:0])},  {16'd3,  12'd0, 4'd1, 32'h0000_00EF});
    check("mis_b1", {b_addr[1][15:0], 12'd0, b_size[1], b_wd[1][31:0]},      {16'd4,  12'd0, 4'd4, 32'h6789_ABCD});
    check("mis_b2", {b_addr[2][15:0], 12'd0, b_size[2], 32'(b_wd[2][15:0])}, {16'd8,  12'd0, 4'd2, 32'h0000_2345});
    check("mis_b3", {b_addr[3][15:0], 12'd0, b_size[3], 32'(b_wd[3][7:0])},  {16'd10, 12'd0, 4'd1, 32'h0000_0001});
    do_req(1'b0, 64'd3, 4'd8, 64'd0);
    check("mis_ld_lat", 64'(lat), 64'd5);
    check("mis_ld_data", r_data, PAT);

    // load splitting
    do_req(1'b1, 64'd6, 4'd2, 64'h1122);
    do_req(1'b1, 64'd8, 4'd2, 64'h3344);
    do_req(1'b0, 64'd6, 4'd2, 64'd0);
    check("sp2_beats", 64'(nbeats), 64'd1);
    check("sp2_b0", {b_addr[0][59:0], b_size[0]}, {60'd6, 4'd2});
    check("sp2_data", r_data, 64'h1122);
    do_req(1'b0, 64'd6, 4'd4, 64'd0);
    check("sp4_beats", 64'(nbeats), 64'd2);
    check("sp4_b0", {b_addr[0][59:0], b_size[0]}, {60'd6, 4'd2});
    check("sp4_b1", {b_addr[1][59:0], b_size[1]}, {60'd8, 4'd2});
    check("sp4_data", r_data, 64'h0000_0000_3344_1122);

    // errors and bounds edges
    e0 = en_cnt;
    do_req(1'b1, 64'd0, 4'd3, PAT);
    check("err_sz_lat", 64'(lat), 64'd1);
    check("err_sz_err", 64'(r_err), 64'd1);
    check("err_sz_rdata", r_data, 64'd0);
    do_req(1'b0, 64'd1020, 4'd8, 64'd0);
    check("err_oob_lat", 64'(lat), 64'd1);
    check("err_oob_err", 64'(r_err), 64'd1);
    check("err_oob_rdata", r_data, 64'd0);
    do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 4'd8, 64'd0);
    check("err_wrap_err", 64'(r_err), 64'd1);
    check("err_no_mem", 64'(en_cnt - e0), 64'd0);
    do_req(1'b0, 64'd1016, 4'd8, 64'd0);
    check("edge_ok_err", 64'(r_err), 64'd0);
    check("edge_ok_lat", 64'(lat), 64'd2);

    // back-to-back with req_valid held
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd16; req_size = 4'd8;
    @(posedge clk);
    #1 req_addr = 64'd6; req_size = 4'd2;
    acc = 0; cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (req_ready) acc++;
    end while (!resp_valid && cyc < 20);
    check("b2b_first_lat", 64'(cyc), 64'd2);
    check("b2b_first_data", resp_rdata, PAT);
    check("b2b_no_accept", 64'(acc), 64'd0);
    @(negedge clk);
    check("b2b_ready_after", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!resp_valid && cyc < 20);
    check("b2b_second_lat", 64'(cyc), 64'd2);
    check("b2b_second_data", resp_rdata, 64'h1122);

    // reset during beat 2 of a misaligned store
    do_req(1'b1, 64'd0, 4'd8, 64'd0);
    do_req(1'b1, 64'd8, 4'd8, 64'd0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd3; req_size = 4'd8; req_wdata = PAT;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rmo_beat2_addr", mem_address, 64'd4);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rmo_en", {62'd0, mem_write_enable, mem_read_enable}, 64'd0);
    check("rmo_ready", 64'(req_ready), 64'd1);
    check("rmo_no_resp", 64'(resp_valid), 64'd0);
    ref_mem[3] = 8'hEF; ref_mem[4] = 8'hCD; ref_mem[5] = 8'hAB; ref_mem[6] = 8'h89; ref_mem[7] = 8'h67;
    do_req(1'b0, 64'd3, 4'd1, 64'd0);
    check("rmo_ld3", r_data, 64'h00EF);
    do_req(1'b0, 64'd8, 4'd2, 64'd0);
    check("rmo_ld8", r_data, 64'h0000);

    // random traffic against a byte reference model
    for (int n = 0; n < 3000; n++) begin
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 8))
        0, 1:    rs = 4'd1;
        2, 3:    rs = 4'd2;
        4, 5:    rs = 4'd4;
        6, 7:    rs = 4'd8;
        default: rs = 4'd3;
      endcase
      ra = 64'($urandom_range(0, 1023));
      ev = {$urandom, $urandom};
      eerr = (rs == 4'd3) || (ra + 64'(rs) > 64'd1024);
      do_req(rw, ra, rs, ev);
      check("rnd_err", 64'(r_err), 64'(eerr));
      if (!rw && !eerr) begin
        ev = '0;
        for (int k = 0; k < int'(rs); k++) ev[8*k +: 8] = ref_mem[(int'(ra[9:0]) + k) & 1023];
        check("rnd_ld", r_data, ev);
      end else begin
        check("rnd_zero", r_data, 64'd0);
      end
    end

    check("align_violations", 64'(viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
